prog_mode_cnt: RTL

PROG_MODE_CNT -- requirements
Module: prog_mode_cnt

---
 rtl/prog_mode_cnt.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/prog_mode_cnt.sv
// Programmable up/down/bounce/one-shot counter with run-time terminal value.
// Optional prescaler enabled by defining PROG_MODE_CNT_PRESCALE_EN.
module prog_mode_cnt #(
  parameter int NBITS = 8
`ifdef PROG_MODE_CNT_PRESCALE_EN
  ,
  parameter int PRE_BITS = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic [NBITS-1:0] lim,
  input  logic [1:0]       mode,
`ifdef PROG_MODE_CNT_PRESCALE_EN
  input  logic [PRE_BITS-1:0] pre_div,
`endif
  output logic [NBITS-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    M_UP      = 2'd0,
    M_DOWN    = 2'd1,
    M_BOUNCE  = 2'd2,
    M_ONESHOT = 2'd3
  } mode_t;

  mode_t            cur_mode;
  logic             step;
  logic [NBITS-1:0] ld_val;
  logic [NBITS-1:0] inc;
  logic [NBITS-1:0] s_cnt;
  logic             s_dir;
  logic             s_tc;
  logic             s_done;

  assign cur_mode = mode_t'(mode);
  assign ld_val   = (load_val < lim) ? load_val : lim;
  assign inc      = count + 1'b1;

`ifdef PROG_MODE_CNT_PRESCALE_EN
  logic [PRE_BITS-1:0] pre_cnt;
  logic                pre_tick;

  assign pre_tick = (pre_cnt == pre_div);
  assign step     = en & pre_tick & ~clr & ~load;
`else
  assign step     = en & ~clr & ~load;
`endif

  // Next state for a qualifying step, per mode.
  always_comb begin
    s_cnt  = count;
    s_dir  = dir;
    s_tc   = 1'b0;
    s_done = done;
    case (cur_mode)
      M_UP: begin
        s_dir = 1'b0;
        if (count < lim) begin
          s_cnt = inc;
        end else begin
          s_cnt = '0;
          s_tc  = 1'b1;
        end
      end
      M_DOWN: begin
        s_dir = 1'b1;
        if (count == '0) begin
          s_cnt = lim;
          s_tc  = 1'b1;
        end else if (count > lim) begin
          s_cnt = lim;
        end else begin
          s_cnt = count - 1'b1;
        end
      end
      M_BOUNCE: begin
        if (lim == '0) begin
          s_cnt = '0;
          s_dir = 1'b0;
          s_tc  = 1'b1;
        end else if (!dir) begin
          if (count < lim) begin
            s_cnt = inc;
          end else begin
            s_cnt = lim - 1'b1;
            s_dir = 1'b1;
            s_tc  = 1'b1;
          end
        end else begin
          if (count != '0) begin
            s_cnt = count - 1'b1;
          end else begin
            s_cnt = {{(NBITS-1){1'b0}}, 1'b1};
            s_dir = 1'b0;
            s_tc  = 1'b1;
          end
        end
      end
      M_ONESHOT: begin
        if (!done) begin
          s_dir = 1'b0;
          // inc is only compared when count < lim, so it cannot overflow there.
          if (count >= lim || inc == lim) begin
            s_cnt  = lim;
            s_done = 1'b1;
            s_tc   = 1'b1;
          end else begin
            s_cnt = inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      dir   <= 1'b0;
      tc    <= 1'b0;
      done  <= 1'b0;
`ifdef PROG_MODE_CNT_PRESCALE_EN
      pre_cnt <= '0;
`endif
    end else if (clr) begin
      count <= '0;
      dir   <= 1'b0;
      tc    <= 1'b0;
      done  <= 1'b0;
`ifdef PROG_MODE_CNT_PRESCALE_EN
      pre_cnt <= '0;
`endif
    end else if (load) begin
      count <= ld_val;
      tc    <= 1'b0;
      done  <= 1'b0;
`ifdef PROG_MODE_CNT_PRESCALE_EN
      pre_cnt <= '0;
`endif
    end else begin
`ifdef PROG_MODE_CNT_PRESCALE_EN
      if (en) begin
        pre_cnt <= pre_tick ? '0 : pre_cnt + 1'b1;
      end
`endif
      if (step) begin
        count <= s_cnt;
        dir   <= s_dir;
        tc    <= s_tc;
        done  <= (cur_mode == M_ONESHOT) & s_done;
      end else begin
        tc <= 1'b0;
        if (cur_mode != M_ONESHOT) begin
          done <= 1'b0;
        end
      end
    end
  end

endmodule
